pipe_stage_reg: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS datapath. It carries a control bundle, a data bundle and a valid bit through DEPTH register stages. It adds stall (hold), flush (bubble insertion), synchronous reset and a saturating flush-event counter. It sits between any two pipeline stages and is driven by the hazard unit.

---
 rtl/pipe_stage_reg_pkg.sv | 53 +++++
 rtl/pipe_stage_reg_slot.sv | 39 +++
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared layout of the inter-stage pipeline bundles: widths and field offsets
// so every pipe_stage_reg instance packs and unpacks control/data the same way.
package pipe_stage_reg_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 13;
  localparam int IDEX_DATA_W  = 186;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  localparam int DEPTH_MAX = 4;

  // ID/EX control bundle, WB bits at the top so later stages slice them off.
  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       wEnable;
    logic       branchSel;
    logic [1:0] regDst;
    logic       aluSrc;
    logic [3:0] aluOp;
    logic       jump;
  } idexCtrl_t;

  // ID/EX data field offsets (LSB of each field)
  localparam int IDEX_SHAMT_LSB  = 0;
  localparam int IDEX_FUNCT_LSB  = 5;
  localparam int IDEX_OP_LSB     = 11;
  localparam int IDEX_JTGT_LSB   = 17;
  localparam int IDEX_RD_LSB     = 43;
  localparam int IDEX_RT_LSB     = 48;
  localparam int IDEX_RS_LSB     = 53;
  localparam int IDEX_IMM_LSB    = 58;
  localparam int IDEX_RTDATA_LSB = 90;
  localparam int IDEX_RSDATA_LSB = 122;
  localparam int IDEX_PC4_LSB    = 154;

  // EX/MEM data field offsets
  localparam int EXMEM_RD_LSB     = 0;
  localparam int EXMEM_STDATA_LSB = 5;
  localparam int EXMEM_ALU_LSB    = 37;
  localparam int EXMEM_PC4_LSB    = 69;

  // MEM/WB data field offsets
  localparam int MEMWB_RD_LSB   = 0;
  localparam int MEMWB_ALU_LSB  = 5;
  localparam int MEMWB_LOAD_LSB = 37;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot holding {valid, ctrl, data}; a bubble clears valid/ctrl,
// load captures the upstream slot, neither means hold.
module pipe_stage_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic              Bubble,
  input  logic              ValidIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Valid,
  output logic [CTRL_W-1:0] Ctrl,
  output logic [DATA_W-1:0] Data
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Valid <= 1'b0;
      Ctrl  <= '0;
      Data  <= '0;
    end else begin
      // ctrl is gated by valid so an empty slot can never assert a write downstream
      if (Bubble) begin
        Valid <= 1'b0;
        Ctrl  <= '0;
      end else if (Load) begin
        Valid <= ValidIn;
        Ctrl  <= ValidIn ? CtrlIn : '0;
      end
      if (Load) Data <= DataIn;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep inter-stage pipeline register with stall, flush bubbles and a
// saturating count of flush-inserted bubbles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W    = IDEX_CTRL_W,
  parameter int DATA_W    = IDEX_DATA_W,
  parameter int DEPTH     = 1,
  parameter int FLUSH_ALL = 0,
  parameter int CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ValidOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut,
  output logic [CNT_W-1:0]  BubbleCount
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : gBadDepth
    $error("pipe_stage_reg: DEPTH out of range");
  end

  logic [DEPTH-1:0]             stgValid, srcValid, stgLoad, stgBubble;
  logic [DEPTH-1:0][CTRL_W-1:0] stgCtrl, srcCtrl;
  logic [DEPTH-1:0][DATA_W-1:0] stgData, srcData;
  logic [CNT_W-1:0]             bubbleCnt;

  for (genvar g = 0; g < DEPTH; g++) begin : gStage
    if (g == 0) begin : gSrcIn
      assign srcValid[g] = ValidIn;
      assign srcCtrl[g]  = CtrlIn;
      assign srcData[g]  = DataIn;
    end else begin : gSrcPrev
      assign srcValid[g] = stgValid[g-1];
      assign srcCtrl[g]  = stgCtrl[g-1];
      assign srcData[g]  = stgData[g-1];
    end

    // Flush outranks stall; in single-stage mode only stage 0 takes the bubble
    // (with fresh data) while the rest keep draining.
    if (FLUSH_ALL != 0) begin : gFlushAll
      assign stgLoad[g]   = ~Flush & ~Stall;
      assign stgBubble[g] = Flush;
    end else if (g == 0) begin : gFlushHead
      assign stgLoad[g]   = Flush | ~Stall;
      assign stgBubble[g] = Flush;
    end else begin : gFlushPass
      assign stgLoad[g]   = Flush | ~Stall;
      assign stgBubble[g] = 1'b0;
    end

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) uSlot (
      .Clock  (Clock),
      .Reset  (Reset),
      .Load   (stgLoad[g]),
      .Bubble (stgBubble[g]),
      .ValidIn(srcValid[g]),
      .CtrlIn (srcCtrl[g]),
      .DataIn (srcData[g]),
      .Valid  (stgValid[g]),
      .Ctrl   (stgCtrl[g]),
      .Data   (stgData[g])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      bubbleCnt <= '0;
    else if (Flush && bubbleCnt != {CNT_W{1'b1}})
      bubbleCnt <= bubbleCnt + CNT_W'(1);
  end

  assign ValidOut    = stgValid[DEPTH-1];
  assign CtrlOut     = stgCtrl[DEPTH-1];
  assign DataOut     = stgData[DEPTH-1];
  assign BubbleCount = bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three configurations share one stimulus stream: A = DEPTH 3 single flush
// CNT_W 4, B = DEPTH 1 defaults, C = DEPTH 3 flush-all CNT_W 4.
module tb_pipe_stage_reg;

  logic         Clock = 1'b0;
  logic         Reset, Stall, Flush, ValidIn;
  logic [12:0]  CtrlIn;
  logic [185:0] DataIn;

  logic         vA, vB, vC;
  logic [12:0]  cA, cB, cC;
  logic [185:0] dA, dB, dC;
  logic [3:0]   nA, nC;
  logic [15:0]  nB;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  pipe_stage_reg #(.CTRL_W(13), .DATA_W(186), .DEPTH(3), .FLUSH_ALL(0), .CNT_W(4)) uA (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .ValidOut(vA), .CtrlOut(cA), .DataOut(dA),
    .BubbleCount(nA));
  pipe_stage_reg #(.CTRL_W(13), .DATA_W(186), .DEPTH(1), .FLUSH_ALL(0), .CNT_W(16)) uB (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .ValidOut(vB), .CtrlOut(cB), .DataOut(dB),
    .BubbleCount(nB));
  pipe_stage_reg #(.CTRL_W(13), .DATA_W(186), .DEPTH(3), .FLUSH_ALL(1), .CNT_W(4)) uC (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .ValidOut(vC), .CtrlOut(cC), .DataOut(dC),
    .BubbleCount(nC));

  // Behavioural reference: a list of slots per configuration, updated per edge.
  typedef struct {
    bit           v;
    logic [12:0]  c;
    logic [185:0] d;
  } slot_t;

  slot_t       m [3][3];
  int unsigned cnt [3];
  int          depthOf [3] = '{3, 1, 3};
  bit          allOf   [3] = '{1'b0, 1'b0, 1'b1};
  int unsigned cmax    [3] = '{15, 65535, 15};

  task automatic modelStep();
    for (int i = 0; i < 3; i++) begin
      if (Reset) begin
        for (int k = 0; k < 3; k++) begin
          m[i][k].v = 1'b0; m[i][k].c = '0; m[i][k].d = '0;
        end
        cnt[i] = 0;
      end else begin
        if (Flush && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
        if (Flush && allOf[i]) begin
          for (int k = 0; k < depthOf[i]; k++) begin
            m[i][k].v = 1'b0; m[i][k].c = '0;
          end
        end else if (Flush || !Stall) begin
          for (int k = depthOf[i] - 1; k > 0; k--) m[i][k] = m[i][k-1];
          m[i][0].v = Flush ? 1'b0 : ValidIn;
          m[i][0].c = (Flush || !ValidIn) ? 13'h0 : CtrlIn;
          m[i][0].d = DataIn;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [185:0] act, input logic [185:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit v,
                      input logic [12:0] c, input logic [185:0] d);
    Reset = r; Stall = s; Flush = f; ValidIn = v; CtrlIn = c; DataIn = d;
    @(posedge Clock);
    modelStep();
    #1;
  endtask

  task automatic chkModel();
    int k;
    k = depthOf[0] - 1;
    chk("A.valid", 186'(vA), 186'(m[0][k].v)); chk("A.ctrl", 186'(cA), 186'(m[0][k].c));
    chk("A.data", dA, m[0][k].d);            chk("A.cnt", 186'(nA), 186'(cnt[0]));
    k = depthOf[1] - 1;
    chk("B.valid", 186'(vB), 186'(m[1][k].v)); chk("B.ctrl", 186'(cB), 186'(m[1][k].c));
    chk("B.data", dB, m[1][k].d);            chk("B.cnt", 186'(nB), 186'(cnt[1]));
    k = depthOf[2] - 1;
    chk("C.valid", 186'(vC), 186'(m[2][k].v)); chk("C.ctrl", 186'(cC), 186'(m[2][k].c));
    chk("C.data", dC, m[2][k].d);            chk("C.cnt", 186'(nC), 186'(cnt[2]));
  endtask

  // Directed vectors for the DEPTH=1 instance, expectations worked by hand.
  typedef struct {
    bit r, s, f, v;
    logic [12:0]  c;
    logic [185:0] d;
    bit           ev;
    logic [12:0]  ec;
    logic [185:0] ed;
    logic [15:0]  en;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [191:0] rnd;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b0; CtrlIn = '0; DataIn = '0;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 3; i++) begin
      m[i][k].v = 1'b0; m[i][k].c = '0; m[i][k].d = '0;
    end
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    tbl[0] = '{1,0,0,1, 13'h1FFF, '1,     0, 13'h0,    186'h0,    16'd0};
    tbl[1] = '{1,0,0,1, 13'h1FFF, '1,     0, 13'h0,    186'h0,    16'd0};
    tbl[2] = '{0,0,0,1, 13'h0A5,  186'h1234, 1, 13'h0A5, 186'h1234, 16'd0};
    tbl[3] = '{0,0,0,0, 13'h1FFF, 186'h55,   0, 13'h0,   186'h55,   16'd0};
    tbl[4] = '{0,0,0,1, 13'h155,  186'h99,   1, 13'h155, 186'h99,   16'd0};
    tbl[5] = '{0,1,0,1, 13'h0AA,  186'h11,   1, 13'h155, 186'h99,   16'd0};
    tbl[6] = '{0,1,1,1, 13'h0AA,  186'h77,   0, 13'h0,   186'h77,   16'd1};
    tbl[7] = '{0,0,1,1, 13'h003,  186'h88,   0, 13'h0,   186'h88,   16'd2};
    tbl[8] = '{0,0,0,1, 13'h1000, 186'h5,    1, 13'h1000, 186'h5,   16'd2};
    tbl[9] = '{1,1,1,1, 13'h1FFF, '1,     0, 13'h0,    186'h0,    16'd0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d.valid", i), 186'(vB), 186'(tbl[i].ev));
      chk($sformatf("vec%0d.ctrl", i),  186'(cB), 186'(tbl[i].ec));
      chk($sformatf("vec%0d.data", i),  dB, tbl[i].ed);
      chk($sformatf("vec%0d.cnt", i),   186'(nB), 186'(tbl[i].en));
    end
    chk("rstA.all", 186'({vA, cA, nA}), 186'h0);
    chk("rstC.all", 186'({vC, cC, nC}), 186'h0);

    // Latency through three stages
    step(0,0,0,1, 13'h0A5, 186'h1234);
    chk("lat1.valid", 186'(vA), 186'h0); chk("lat1.data", dA, 186'h0);
    step(0,0,0,0, 13'h0, 186'h0);
    chk("lat2.valid", 186'(vA), 186'h0); chk("lat2.data", dA, 186'h0);
    step(0,0,0,0, 13'h0, 186'h0);
    chk("lat3.valid", 186'(vA), 186'h1); chk("lat3.ctrl", 186'(cA), 186'h0A5);
    chk("lat3.data", dA, 186'h1234);

    // Stall hold on the single-stage instance
    step(0,0,0,1, 13'h155, 186'hAB);
    chk("hold.load", 186'(cB), 186'h155);
    for (int i = 0; i < 5; i++) begin
      step(0,1,0,1, 13'h0AA, 186'hCD);
      chk($sformatf("hold%0d.ctrl", i), 186'(cB), 186'h155);
      chk($sformatf("hold%0d.data", i), dB, 186'hAB);
      chk($sformatf("hold%0d.valid", i), 186'(vB), 186'h1);
    end
    step(0,0,0,1, 13'h0AA, 186'hCD);
    chk("release.ctrl", 186'(cB), 186'h0AA);

    // Flush-all versus head-only flush with three resident instructions
    step(1,0,0,0, 13'h0, 186'h0);
    step(0,0,0,1, 13'h1, 186'h10);
    step(0,0,0,1, 13'h2, 186'h20);
    step(0,0,0,1, 13'h3, 186'h30);
    step(0,0,1,1, 13'h7, 186'h70);
    chk("fa0.C", 186'({vC, cC}), 186'h0); chk("fa0.Cdata", dC, 186'h10);
    chk("fa0.Ccnt", 186'(nC), 186'h1);
    chk("fa0.A", 186'({vA, cA}), 186'({1'b1, 13'h2})); chk("fa0.Adata", dA, 186'h20);
    step(0,0,0,0, 13'h0, 186'h0);
    chk("fa1.C", 186'({vC, cC}), 186'h0); chk("fa1.Cdata", dC, 186'h20);
    chk("fa1.A", 186'({vA, cA}), 186'({1'b1, 13'h3})); chk("fa1.Adata", dA, 186'h30);
    step(0,0,0,0, 13'h0, 186'h0);
    chk("fa2.C", 186'({vC, cC}), 186'h0); chk("fa2.Cdata", dC, 186'h30);
    chk("fa2.A", 186'({vA, cA}), 186'h0); chk("fa2.Adata", dA, 186'h70);

    // Counter saturation
    step(1,0,0,0, 13'h0, 186'h0);
    for (int i = 0; i < 20; i++) begin
      step(0, i[0], 1, 1, 13'h1FFF, 186'(i));
      if (i == 13) chk("sat14.A", 186'(nA), 186'd14);
      if (i == 14) chk("sat15.A", 186'(nA), 186'd15);
    end
    chk("sat.A", 186'(nA), 186'd15);
    chk("sat.C", 186'(nC), 186'd15);
    chk("sat.B", 186'(nB), 186'd20);
    chk("sat.Bvalid", 186'({vB, cB}), 186'h0);
    step(1,0,0,0, 13'h0, 186'h0);
    chk("satrst.A", 186'(nA), 186'h0);
    chk("satrst.B", 186'(nB), 186'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom), 13'($urandom_range(0, 8191)),
           rnd[185:0]);
      chkModel();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
